// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Accepts one load or store at a time, holds the pipeline with stall while
// WAIT_CYCLES wait states elapse, then completes the access in DONE.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   mem_read, mem_write request strobes from the MEM stage
//   addr, wdata         byte address and store data
//   rdata, rdata_valid  load data and its one-cycle completion pulse
//   stall               hold the pipeline (request inputs held stable)
//   addr_err            one-cycle pulse after a rejected request
//   rd_count, wr_count  saturating completed-load / completed-store counters
//
// state | meaning
// IDLE  | waiting for a request; legal request raises stall combinationally
// WAIT  | wait states counting down, stall held high
// DONE  | access completes, stall low so the pipeline advances
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             rdata_valid,
   output logic             stall,
   output logic             addr_err,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] wr_count
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

   stateT            state;
   logic [3:0]       waitCnt;
   logic             opWrite;
   logic [AW-1:0]    wordIdx;
   logic [31:0]      wdataQ;
   logic [31:0]      mem [DEPTH_WORDS];

   logic             reqOne;
   logic             reqLegal;
   logic             reqIllegal;
   logic             enterDone;
   logic             accWrite;
   logic [AW-1:0]    accIdx;
   logic [31:0]      accData;

   always_comb begin
      reqOne     = mem_read ^ mem_write;
      reqLegal   = reqOne && (addr[1:0] == 2'b00) && (addr[31:2] < 30'(DEPTH_WORDS));
      reqIllegal = (mem_read && mem_write) || (reqOne && !reqLegal);
      stall      = ((state == IDLE) && reqLegal) || (state == WAIT);

      // With zero wait states the access completes straight from IDLE, so the
      // live inputs are used instead of the captured copies.
      enterDone  = ((state == WAIT) && (waitCnt == 4'd0)) ||
                   ((state == IDLE) && reqLegal && ZERO_WAIT);
      if (state == IDLE) begin
         accWrite = mem_write;
         accIdx   = addr[AW+1:2];
         accData  = wdata;
      end else begin
         accWrite = opWrite;
         accIdx   = wordIdx;
         accData  = wdataQ;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         waitCnt     <= 4'd0;
         opWrite     <= 1'b0;
         wordIdx     <= '0;
         wdataQ      <= 32'd0;
         rdata       <= 32'd0;
         rdata_valid <= 1'b0;
         addr_err    <= 1'b0;
         rd_count    <= '0;
         wr_count    <= '0;
      end else begin
         rdata_valid <= 1'b0;
         addr_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (reqLegal) begin
                  opWrite <= mem_write;
                  wordIdx <= addr[AW+1:2];
                  wdataQ  <= wdata;
                  if (ZERO_WAIT) begin
                     state <= DONE;
                  end else begin
                     state   <= WAIT;
                     waitCnt <= WAIT_LOAD;
                  end
               end else if (reqIllegal) begin
                  addr_err <= 1'b1;
               end
            end
            WAIT: begin
               if (waitCnt == 4'd0) state <= DONE;
               else waitCnt <= waitCnt - 4'd1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase

         if (enterDone) begin
            if (accWrite) begin
               if (wr_count != '1) wr_count <= wr_count + CNT_W'(1);
            end else begin
               rdata       <= mem[accIdx];
               rdata_valid <= 1'b1;
               if (rd_count != '1) rd_count <= rd_count + CNT_W'(1);
            end
         end
      end
   end

   // Array is not reset; a reset on the commit edge suppresses the store.
   always_ff @(posedge clk) begin
      if (rst_n && enterDone && accWrite) mem[accIdx] <= accData;
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        mrA, mwA, rvA, stallA, aeA;
   logic [31:0] addrA, wdA, rdataA;
   logic [15:0] rcA, wcA;
   logic        mrB, mwB, rvB, stallB, aeB;
   logic [31:0] addrB, wdB, rdataB;
   logic [1:0]  rcB, wcB;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .CNT_W(16)) dutA (
      .clk(clk), .rst_n(rst_n), .mem_read(mrA), .mem_write(mwA), .addr(addrA),
      .wdata(wdA), .rdata(rdataA), .rdata_valid(rvA), .stall(stallA),
      .addr_err(aeA), .rd_count(rcA), .wr_count(wcA));

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .CNT_W(2)) dutB (
      .clk(clk), .rst_n(rst_n), .mem_read(mrB), .mem_write(mwB), .addr(addrB),
      .wdata(wdB), .rdata(rdataB), .rdata_valid(rvB), .stall(stallB),
      .addr_err(aeB), .rd_count(rcB), .wr_count(wcB));

   task automatic drive(input bit sel, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (sel) begin
         mrB = rd; mwB = wr; addrB = a; wdB = d;
      end else begin
         mrA = rd; mwA = wr; addrA = a; wdA = d;
      end
   endtask

   task automatic idle(input bit sel);
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   // Issues a request and follows it to the first cycle with stall low.
   task automatic access(input bit sel, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d,
                         output int stallCyc, output bit done, output bit validEarly,
                         output bit validDone, output logic [31:0] dataDone,
                         output int doneCyc);
      stallCyc = 0; done = 0; validEarly = 0; validDone = 0;
      dataDone = 32'd0; doneCyc = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (i == 0) drive(sel, rd, wr, a, d);
         #1;
         if (sel ? stallB : stallA) begin
            stallCyc++;
            if (sel ? rvB : rvA) validEarly = 1;
         end else begin
            done      = 1;
            validDone = sel ? rvB : rvA;
            dataDone  = sel ? rdataB : rdataA;
            doneCyc   = cyc;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drive(0, 0, 0, 32'd0, 32'd0);
      drive(1, 0, 0, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      #1;
      checks++; if (stallA !== 1'b0) $display("FAIL reset_stall got %b want 0", stallA); else passes++;
      checks++; if (rvA !== 1'b0) $display("FAIL reset_valid got %b want 0", rvA); else passes++;
      checks++; if (aeA !== 1'b0) $display("FAIL reset_addr_err got %b want 0", aeA); else passes++;
      checks++; if (rdataA !== 32'd0) $display("FAIL reset_rdata got %h want 0", rdataA); else passes++;
      checks++; if (rcA !== 16'd0 || wcA !== 16'd0) $display("FAIL reset_counts got %0d/%0d want 0/0", rcA, wcA); else passes++;
      checks++; if (rcB !== 2'd0 || wcB !== 2'd0) $display("FAIL reset_counts_b got %0d/%0d want 0/0", rcB, wcB); else passes++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_store;
      int sc, dc; bit dn, ve, vd; logic [31:0] dd;
      access(0, 0, 1, 32'h10, 32'hDEADBEEF, sc, dn, ve, vd, dd, dc);
      checks++; if (!dn) $display("FAIL store_timeout got no completion want completion"); else passes++;
      checks++; if (sc !== 3) $display("FAIL store_stall_cycles got %0d want 3", sc); else passes++;
      checks++; if (ve || vd) $display("FAIL store_no_valid got %b%b want 00", ve, vd); else passes++;
      checks++; if (wcA !== 16'd1) $display("FAIL store_wr_count got %0d want 1", wcA); else passes++;
      checks++; if (rcA !== 16'd0) $display("FAIL store_rd_count got %0d want 0", rcA); else passes++;
      idle(0);
   endtask

   task automatic test_load;
      int sc, dc; bit dn, ve, vd; logic [31:0] dd;
      access(0, 1, 0, 32'h10, 32'd0, sc, dn, ve, vd, dd, dc);
      checks++; if (!dn) $display("FAIL load_timeout got no completion want completion"); else passes++;
      checks++; if (sc !== 3) $display("FAIL load_stall_cycles got %0d want 3", sc); else passes++;
      checks++; if (vd !== 1'b1 || ve) $display("FAIL load_valid got early=%b done=%b want 0/1", ve, vd); else passes++;
      checks++; if (dd !== 32'hDEADBEEF) $display("FAIL load_data got %h want deadbeef", dd); else passes++;
      checks++; if (rcA !== 16'd1) $display("FAIL load_rd_count got %0d want 1", rcA); else passes++;
      idle(0);
      #1;
      checks++; if (rvA !== 1'b0) $display("FAIL load_valid_drop got %b want 0", rvA); else passes++;
      checks++; if (rdataA !== 32'hDEADBEEF) $display("FAIL load_rdata_hold got %h want deadbeef", rdataA); else passes++;
   endtask

   task automatic test_back_to_back;
      int sc, dc1, dc2; bit dn1, dn2, ve, vd1, vd2; logic [31:0] d1, d2;
      access(0, 0, 1, 32'h14, 32'h12345678, sc, dn1, ve, vd1, d1, dc1);
      idle(0);
      access(0, 1, 0, 32'h10, 32'd0, sc, dn1, ve, vd1, d1, dc1);
      access(0, 1, 0, 32'h14, 32'd0, sc, dn2, ve, vd2, d2, dc2);
      idle(0);
      checks++; if (!dn1 || !dn2) $display("FAIL b2b_timeout got %b%b want 11", dn1, dn2); else passes++;
      checks++; if (!vd1 || !vd2) $display("FAIL b2b_valid got %b%b want 11", vd1, vd2); else passes++;
      checks++; if (d1 !== 32'hDEADBEEF) $display("FAIL b2b_data1 got %h want deadbeef", d1); else passes++;
      checks++; if (d2 !== 32'h12345678) $display("FAIL b2b_data2 got %h want 12345678", d2); else passes++;
      checks++; if (dc2 - dc1 != 4) $display("FAIL b2b_spacing got %0d want 4", dc2 - dc1); else passes++;
      checks++; if (rcA !== 16'd3 || wcA !== 16'd2) $display("FAIL b2b_counts got %0d/%0d want 3/2", rcA, wcA); else passes++;
   endtask

   task automatic test_illegal;
      logic [31:0] va [3];
      bit          vr [3];
      int sc, dc; bit dn, ve, vd; logic [31:0] dd;
      va = '{32'h13, 32'h14, 32'h400};
      vr = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(0, vr[i], 1'b1, va[i], 32'hFFFFFFFF);
         #1;
         checks++; if (stallA !== 1'b0) $display("FAIL illegal%0d_stall got %b want 0", i, stallA); else passes++;
         @(negedge clk);
         drive(0, 0, 0, 32'd0, 32'd0);
         #1;
         checks++; if (aeA !== 1'b1) $display("FAIL illegal%0d_addr_err got %b want 1", i, aeA); else passes++;
         @(negedge clk);
         #1;
         checks++; if (aeA !== 1'b0) $display("FAIL illegal%0d_err_pulse got %b want 0", i, aeA); else passes++;
         checks++; if (rcA !== 16'd3 || wcA !== 16'd2) $display("FAIL illegal%0d_counts got %0d/%0d want 3/2", i, rcA, wcA); else passes++;
      end
      access(0, 1, 0, 32'h10, 32'd0, sc, dn, ve, vd, dd, dc);
      checks++; if (dd !== 32'hDEADBEEF || !vd) $display("FAIL illegal_mem10 got %h want deadbeef", dd); else passes++;
      access(0, 1, 0, 32'h14, 32'd0, sc, dn, ve, vd, dd, dc);
      checks++; if (dd !== 32'h12345678 || !vd) $display("FAIL illegal_mem14 got %h want 12345678", dd); else passes++;
      idle(0);
   endtask

   task automatic test_rdata_hold;
      int sc, dc; bit dn, ve, vd; logic [31:0] dd;
      access(0, 0, 1, 32'h18, 32'h55AA55AA, sc, dn, ve, vd, dd, dc);
      checks++; if (dd !== 32'h12345678 || vd) $display("FAIL hold_rdata got %h valid %b want 12345678 valid 0", dd, vd); else passes++;
      checks++; if (wcA !== 16'd3 || rcA !== 16'd5) $display("FAIL hold_counts got %0d/%0d want 5/3", rcA, wcA); else passes++;
      idle(0);
   endtask

   task automatic test_reset_mid_store;
      int sc, dc; bit dn, ve, vd; logic [31:0] dd;
      access(0, 0, 1, 32'h20, 32'h11112222, sc, dn, ve, vd, dd, dc);
      idle(0);
      @(negedge clk);
      drive(0, 0, 1, 32'h20, 32'h0BADF00D);
      @(negedge clk);
      @(negedge clk);
      // Reset lands on the edge that would otherwise commit the store.
      rst_n = 1'b0;
      drive(0, 0, 0, 32'd0, 32'd0);
      #1;
      checks++; if (stallA !== 1'b1) $display("FAIL midrst_in_wait got %b want 1", stallA); else passes++;
      @(negedge clk);
      #1;
      checks++; if (rvA !== 1'b0 || aeA !== 1'b0) $display("FAIL midrst_pulses got %b%b want 00", rvA, aeA); else passes++;
      checks++; if (wcA !== 16'd0 || rcA !== 16'd0) $display("FAIL midrst_counts got %0d/%0d want 0/0", rcA, wcA); else passes++;
      checks++; if (stallA !== 1'b0) $display("FAIL midrst_stall got %b want 0", stallA); else passes++;
      rst_n = 1'b1;
      access(0, 1, 0, 32'h20, 32'd0, sc, dn, ve, vd, dd, dc);
      checks++; if (dd !== 32'h11112222 || !vd) $display("FAIL midrst_mem got %h want 11112222", dd); else passes++;
      checks++; if (rcA !== 16'd1 || wcA !== 16'd0) $display("FAIL midrst_after_counts got %0d/%0d want 1/0", rcA, wcA); else passes++;
      idle(0);
   endtask

   task automatic test_wait0;
      int sc, dc; bit dn, ve, vd; logic [31:0] dd;
      logic [1:0] expRc;
      access(1, 0, 1, 32'h8, 32'hCAFEF00D, sc, dn, ve, vd, dd, dc);
      checks++; if (sc !== 1 || !dn) $display("FAIL w0_store_stall got %0d want 1", sc); else passes++;
      checks++; if (wcB !== 2'd1) $display("FAIL w0_wr_count got %0d want 1", wcB); else passes++;
      idle(1);
      for (int k = 1; k <= 5; k++) begin
         access(1, 1, 0, 32'h8, 32'd0, sc, dn, ve, vd, dd, dc);
         expRc = (k < 3) ? 2'(k) : 2'd3;
         checks++; if (sc !== 1 || ve || !vd) $display("FAIL w0_load%0d_timing got stall %0d valid %b want 1 1", k, sc, vd); else passes++;
         checks++; if (dd !== 32'hCAFEF00D) $display("FAIL w0_load%0d_data got %h want cafef00d", k, dd); else passes++;
         checks++; if (rcB !== expRc) $display("FAIL w0_load%0d_rd_count got %0d want %0d", k, rcB, expRc); else passes++;
      end
      idle(1);
   endtask

   initial begin
      test_reset;
      test_store;
      test_load;
      test_back_to_back;
      test_illegal;
      test_rdata_hold;
      test_reset_mid_store;
      test_wait0;
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
